nibble_serial_adder: RTL and testbench

- Multi-cycle WIDTH-bit adder built around one shared instance of the team's 4-bit ripple-carry adder (fourbit_FA_H).
- Latches two operands on a start handshake, feeds the 4-bit adder one nibble per clock (LSB nibble first), and registers the inter-nibble carry.
- Reassembles the full sum and signals completion with a one-cycle done pulse.
- Sits directly upstream of fourbit_FA_H as its sequencer, trading latency for area on wide adds.

---
 rtl/nibble_serial_adder.sv | 134 +++++++++++++
 tb/tb_nibble_serial_adder.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder sequencing one shared 4-bit ripple-carry adder, LSB nibble first.
// Optional subtract mode is enabled by defining NIBBLE_SERIAL_SUB_EN (adds the sub port).

module fourbit_FA_H (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] sum,
    output logic       c_out
);
    logic carry;

    always_comb begin
        carry = c_in;
        sum   = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        c_out = carry;
    end
endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
`ifdef NIBBLE_SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_reg, b_reg, psum, psum_next;
    logic [WIDTH-1:0] b_in;
    logic             cin_in;
    logic             carry_reg;
    logic [CW-1:0]    cnt;
    logic             last;
    logic [3:0]       add_sum;
    logic             add_c;

`ifdef NIBBLE_SERIAL_SUB_EN
    // Subtraction as a + ~b + 1; c_out=1 then means no borrow.
    assign b_in   = sub ? ~b : b;
    assign cin_in = sub ? 1'b1 : c_in;
`else
    assign b_in   = b;
    assign cin_in = c_in;
`endif

    fourbit_FA_H u_fa (
        .a     (a_reg[3:0]),
        .b     (b_reg[3:0]),
        .c_in  (carry_reg),
        .sum   (add_sum),
        .c_out (add_c)
    );

    // New nibble enters at the MSB end; written as a shift-or so WIDTH=4 needs no special case.
    assign psum_next = (psum >> 4) | (WIDTH'(add_sum) << (WIDTH - 4));
    assign last      = (cnt == CW'(NIB - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: if (start) state_next = RUN;
            RUN: begin
                busy = 1'b1;
                if (last) state_next = DONE;
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            psum      <= '0;
            carry_reg <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            c_out     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    a_reg     <= a;
                    b_reg     <= b_in;
                    carry_reg <= cin_in;
                    cnt       <= '0;
                    psum      <= '0;
                end
                RUN: begin
                    psum      <= psum_next;
                    carry_reg <= add_c;
                    a_reg     <= a_reg >> 4;
                    b_reg     <= b_reg >> 4;
                    cnt       <= cnt + 1'b1;
                    if (last) begin
                        sum   <= psum_next;
                        c_out <= add_c;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder (WIDTH=16): expected {c_out,sum} queued on request,
// popped by a done monitor.

module tb_nibble_serial_adder;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        c_in = 1'b0;
`ifdef NIBBLE_SERIAL_SUB_EN
    logic        sub = 1'b0;
`endif
    logic        busy, done, c_out;
    logic [15:0] sum;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_done   = 0;
    logic [16:0] exp_q[$];
    logic [16:0] prev_result = '0;

    nibble_serial_adder #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
`ifdef NIBBLE_SERIAL_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .c_out (c_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard side: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            n_done++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                check("sum", 32'(sum), 32'(e[15:0]));
                check("c_out", 32'(c_out), 32'(e[16]));
                prev_result = e;
            end
        end
    end

    // Drives one request and follows it through to DONE; lock_a/lock_b (if lock) are presented
    // with start=1 during RUN and must be ignored.
    task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic ci,
                          input logic s, input logic lock,
                          input logic [15:0] lock_a, input logic [15:0] lock_b);
        logic [16:0] e;
        int          cycles;
        logic        seen;
        if (s) e = {1'b0, x} + {1'b0, ~y} + 17'd1;
        else   e = {1'b0, x} + {1'b0, y} + 17'(ci);
        @(negedge clk);
        a = x; b = y; c_in = ci; start = 1'b1;
`ifdef NIBBLE_SERIAL_SUB_EN
        sub = s;
`endif
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a = $urandom; b = $urandom; c_in = $urandom_range(0, 1);
        check("busy_run", 32'(busy), 32'd1);
        check("hold_sum", 32'({c_out, sum}), 32'(prev_result));
        cycles = 1;
        seen   = 1'b0;
        while (cycles < 20 && !seen) begin
            if (lock && cycles == 2) begin
                start = 1'b1; a = lock_a; b = lock_b;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cycles++;
            if (done === 1'b1) seen = 1'b1;
            else check("busy_hold", 32'(busy), 32'd1);
        end
        start = 1'b0;
        check("latency", 32'(cycles), 32'd5);
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int d0;
        // Reset with start held high: must be ignored.
        rst = 1'b1; start = 1'b1; a = 16'h1111; b = 16'h2222;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(c_out), 32'd0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, '0, '0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, '0, '0);
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0, '0, '0);

        // Busy lockout: a second start during RUN must not be queued or executed.
        d0 = n_done;
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1, 16'hAAAA, 16'h5555);
        repeat (8) @(negedge clk);
        check("lockout_dones", 32'(n_done - d0), 32'd1);
        check("lockout_busy", 32'(busy), 32'd0);

        // Mid-run reset aborts the add.
        d0 = n_done;
        @(negedge clk);
        a = 16'h00FF; b = 16'h0001; c_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_sum", 32'({c_out, sum}), 32'd0);
        rst = 1'b0;
        prev_result = '0;
        repeat (8) @(negedge clk);
        check("abort_no_done", 32'(n_done - d0), 32'd0);
        run_op(16'h0010, 16'h0020, 1'b0, 1'b0, 1'b0, '0, '0);

        for (int i = 0; i < 6; i++)
            run_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'b0, '0, '0);

`ifdef NIBBLE_SERIAL_SUB_EN
        run_op(16'h0007, 16'h0005, 1'b1, 1'b1, 1'b0, '0, '0);
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, '0, '0);
`endif

        repeat (3) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
